lsq_fwd_queue: RTL
==================

# lsq_fwd_queue

Parametrised load/store queue between the core memory stage and the data memory system. It replaces the fixed 16-entry FIFO LSQ and adds:
- a real full/ready handshake;
- issue back-pressure from memory;
- out-of-order completion with in-order retirement;
- store-to-load forwarding.

Loads whose word address matches an older in-queue store complete without a memory access.

## Interface
Parameters:
- DEPTH, 16, entries; power of two, ≥4
- AW, 32, address width
- DW, 32, data width
- CW, 4, control-field width (carried, not interpreted)
- TW, 4, destination-tag (Z) width (carried, not interpreted)
- IDW, $clog2(DEPTH), entry-ID width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- enq_valid  in  1  core presents a load/store
- enq_ready  out  1  queue can accept (not full)
- enq_is_store  in  1  1=store, 0=load
- enq_addr  in  AW  byte address
- enq_data  in  DW  store data (ignored for loads)
- enq_cntrl  in  CW  control passed to retire
- enq_tag  in  TW  Z tag passed to retire
- mem_valid  out  1  request valid
- mem_stall  in  1  memory cannot accept this cycle
- mem_rw  out  1  1=write, 0=read
- mem_addr  out  AW  request address
- mem_data  out  DW  write data
- mem_id  out  IDW  entry ID
- rsp_valid  in  1  memory completion
- rsp_id  in  IDW  completed entry ID
- rsp_data  in  DW  read data (stores: ignored)
- ret_valid  out  1  head entry complete
- ret_ready  in  1  core accepts retire
- ret_is_store / ret_fwd  out  1 each  head kind / head load was forwarded
- ret_addr / ret_data / ret_cntrl / ret_tag  out  AW/DW/CW/TW  head fields
- empty  out  1  no entries
- count  out  IDW+1  occupancy
- proto_err  out  1  sticky: response to an entry not in ISSUED

## Operation
- Per-entry state: FREE, PEND (awaiting issue), ISSUED, DONE. Head, issue and tail pointers are IDW+1 bits; the MSB is the wrap bit.
- count = tail - head. full = (count == DEPTH). enq_ready = !full. empty = (count == 0).
- Enqueue happens on enq_valid && enq_ready. The entry is written at tail and tail increments.
- Load forwarding search at enqueue:
  - Search all valid entries older than the new one (head..tail-1) for stores with addr[AW-1:2] equal to enq_addr[AW-1:2].
  - On a hit, the youngest matching store supplies the data. The load is written DONE with ret_fwd=1 and is never issued.
  - On a miss, the load is written PEND.
  - Stores are always written PEND.
- Issue:
  - The issue pointer walks in program order and skips DONE (forwarded) entries at one entry per cycle.
  - When the entry at the issue pointer is PEND and no request is outstanding in the output register, it is loaded into the mem_* registers. mem_valid=1 and the entry goes to ISSUED.
  - The request transfers on a cycle with mem_valid && !mem_stall. mem_valid then drops unless a new PEND entry is loaded the same edge.
  - While mem_stall=1, all mem_* outputs are held stable.
- Completion:
  - rsp_valid with rsp_id in ISSUED moves the entry to DONE. Loads capture rsp_data.
  - rsp_valid with rsp_id in any other state leaves the entry unchanged and sets proto_err.
- Retire:
  - ret_* reflect the head entry. ret_valid = head state DONE && !empty.
  - On ret_valid && ret_ready, the head becomes FREE and head increments.
- Simultaneous events in one cycle:
  - Enqueue, issue transfer, response and retire may all occur together; each updates a different entry.
  - When full, enq_ready=0 even if a retire happens that cycle (no same-cycle slot reuse).
  - A retiring store is still visible to a load enqueued in the same cycle.
- Addresses and pointers wrap modulo DEPTH using the low IDW bits. The wrap bit distinguishes full from empty.

## Timing
- Reset asserted (async):
  - all entries FREE; pointers 0; count=0;
  - enq_ready=1, empty=1;
  - mem_valid=0, ret_valid=0, proto_err=0;
  - all data outputs 0.
- Reset asserted mid-operation discards all entries and any outstanding request.
- Enqueue accepted at edge E gives mem_valid=1 after edge E+1 (when the issue pointer is at that entry and the output register is free).
- Forwarded load at head gives ret_valid=1 after edge E.
- Response at edge R, entry at head, gives ret_valid=1 after edge R.
- Retire pop is one entry per cycle.
- Issue throughput is one request per cycle with mem_stall=0.
- Forwarding search is combinational within the enqueue cycle.

## Structure
- Package lsq_pkg holds:
  - the entry-state enum (FREE/PEND/ISSUED/DONE);
  - the entry struct (is_store, fwd, addr, data, cntrl, tag);
  - default parameter constants.
- Sub-module lsq_fwd_match: age-ordered youngest-match priority search over DEPTH entries, given head/tail pointers. It returns hit and entry index.

## Test plan
- Reset, then 16 stores to 0x100..0x13C with mem_stall=0 → enq_ready low after the 16th, count=16. Memory sees IDs 0..15 in order. Retire in order after responses.
- Store 0xDEADBEEF to 0x40, then load 0x42 before any response → load ret_fwd=1, ret_data=0xDEADBEEF, no memory read issued.
- Two stores to 0x80 (0x1, 0x2), then load 0x80 → forwarded data 0x2.
- Loads IDs 0,1,2 answered in order 2,0,1 → retire strictly 0,1,2 with the matching data.
- Hold mem_stall=1 for 5 cycles with 3 pending → mem_* stable, no ISSUED advance. Release → 3 transfers on consecutive cycles.
- Response with a FREE rsp_id → proto_err=1 and stays 1. Async reset mid-burst → all outputs return to reset values immediately.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared entry-state encoding, entry layout and default sizes for the load/store forwarding queue.
package lsq_pkg;

  localparam int LSQ_DEPTH = 16;
  localparam int LSQ_AW    = 32;
  localparam int LSQ_DW    = 32;
  localparam int LSQ_CW    = 4;
  localparam int LSQ_TW    = 4;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_DONE   = 2'd3
  } lsq_state_e;

  // Entry layout at the default widths; the queue builds the same shape at its instance widths.
  typedef struct packed {
    logic              is_store;
    logic              fwd;
    logic [LSQ_AW-1:0] addr;
    logic [LSQ_DW-1:0] data;
    logic [LSQ_CW-1:0] cntrl;
    logic [LSQ_TW-1:0] tag;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_fwd_match.sv
// Youngest-match priority search over the occupied ring window [head, tail).
// Purely combinational, zero latency; no flow control of its own.
module lsq_fwd_match #(
  parameter int DEPTH = 16,
  parameter int IDW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [IDW:0]     head,
  input  logic [IDW:0]     tail,
  output logic             hit,
  output logic [IDW-1:0]   idx
);

  logic [IDW:0]   occ;
  logic [IDW-1:0] pos;

  assign occ = tail - head;

  // Walk oldest to youngest so the last hit found is the youngest matching store.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head[IDW-1:0] + IDW'(k);
      if (((IDW+1)'(k) < occ) && match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/lsq_fwd_queue.sv
// Load/store queue: in-order issue, out-of-order completion, in-order retire, store-to-load forwarding.
// Issue one cycle after enqueue; mem_stall freezes the request register; enq_ready drops only when full.
module lsq_fwd_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH,
  parameter int AW    = LSQ_AW,
  parameter int DW    = LSQ_DW,
  parameter int CW    = LSQ_CW,
  parameter int TW    = LSQ_TW,
  parameter int IDW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enq_valid,
  output logic           enq_ready,
  input  logic           enq_is_store,
  input  logic [AW-1:0]  enq_addr,
  input  logic [DW-1:0]  enq_data,
  input  logic [CW-1:0]  enq_cntrl,
  input  logic [TW-1:0]  enq_tag,
  output logic           mem_valid,
  input  logic           mem_stall,
  output logic           mem_rw,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_data,
  output logic [IDW-1:0] mem_id,
  input  logic           rsp_valid,
  input  logic [IDW-1:0] rsp_id,
  input  logic [DW-1:0]  rsp_data,
  output logic           ret_valid,
  input  logic           ret_ready,
  output logic           ret_is_store,
  output logic           ret_fwd,
  output logic [AW-1:0]  ret_addr,
  output logic [DW-1:0]  ret_data,
  output logic [CW-1:0]  ret_cntrl,
  output logic [TW-1:0]  ret_tag,
  output logic           empty,
  output logic [IDW:0]   count,
  output logic           proto_err
);

  // Same layout as lsq_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic          is_store;
    logic          fwd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cntrl;
    logic [TW-1:0] tag;
  } entry_t;

  lsq_state_e       st  [DEPTH];
  entry_t           ent [DEPTH];
  logic [IDW:0]     head, iss, tail;
  logic [IDW-1:0]   head_i, iss_i, tail_i;
  logic             full, enq_fire, ret_fire, out_free;
  logic             fwd_hit, fwd_load;
  logic [IDW-1:0]   fwd_idx;
  logic [DEPTH-1:0] match_vec;
  entry_t           new_ent;

  assign head_i = head[IDW-1:0];
  assign iss_i  = iss[IDW-1:0];
  assign tail_i = tail[IDW-1:0];

  assign count     = tail - head;
  assign full      = (count == (IDW+1)'(DEPTH));
  assign enq_ready = !full;
  assign empty     = (count == '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign ret_valid = !empty && (st[head_i] == ST_DONE);
  assign ret_fire  = ret_valid && ret_ready;
  assign out_free  = !mem_valid || !mem_stall;

  assign ret_is_store = ent[head_i].is_store;
  assign ret_fwd      = ent[head_i].fwd;
  assign ret_addr     = ent[head_i].addr;
  assign ret_data     = ent[head_i].data;
  assign ret_cntrl    = ent[head_i].cntrl;
  assign ret_tag      = ent[head_i].tag;

  // A retiring head store is still non-FREE this cycle, so it remains a forwarding source.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = (st[i] != ST_FREE) && ent[i].is_store &&
                     (ent[i].addr[AW-1:2] == enq_addr[AW-1:2]);
    end
  end

  lsq_fwd_match #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_match (
    .match (match_vec),
    .head  (head),
    .tail  (tail),
    .hit   (fwd_hit),
    .idx   (fwd_idx)
  );

  assign fwd_load = !enq_is_store && fwd_hit;

  always_comb begin
    new_ent          = '0;
    new_ent.is_store = enq_is_store;
    new_ent.fwd      = fwd_load;
    new_ent.addr     = enq_addr;
    new_ent.cntrl    = enq_cntrl;
    new_ent.tag      = enq_tag;
    if (enq_is_store) begin
      new_ent.data = enq_data;
    end else if (fwd_load) begin
      new_ent.data = ent[fwd_idx].data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      iss       <= '0;
      tail      <= '0;
      proto_err <= 1'b0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_id    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st[i]  <= ST_FREE;
        ent[i] <= '0;
      end
    end else begin
      if (mem_valid && !mem_stall) begin
        mem_valid <= 1'b0;
      end

      // Forwarded loads are skipped; PEND entries wait for a free request register.
      if (iss != tail) begin
        if (st[iss_i] == ST_DONE) begin
          iss <= iss + 1'b1;
        end else if (st[iss_i] == ST_PEND && out_free) begin
          mem_valid  <= 1'b1;
          mem_rw     <= ent[iss_i].is_store;
          mem_addr   <= ent[iss_i].addr;
          mem_data   <= ent[iss_i].data;
          mem_id     <= iss_i;
          st[iss_i]  <= ST_ISSUED;
          iss        <= iss + 1'b1;
        end
      end

      if (rsp_valid) begin
        if (st[rsp_id] == ST_ISSUED) begin
          st[rsp_id] <= ST_DONE;
          if (!ent[rsp_id].is_store) begin
            ent[rsp_id].data <= rsp_data;
          end
        end else begin
          proto_err <= 1'b1;
        end
      end

      if (ret_fire) begin
        st[head_i] <= ST_FREE;
        head       <= head + 1'b1;
      end

      if (enq_fire) begin
        st[tail_i]  <= fwd_load ? ST_DONE : ST_PEND;
        ent[tail_i] <= new_ent;
        tail        <= tail + 1'b1;
      end
    end
  end

endmodule
